// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared forwarding selects, stall FSM states and default widths for hazard_ctrl.
package hazard_pkg;
  localparam int REG_W_DEF = 5;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WR = 2'b10;
  typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side register indices and write enables in, forwarding/hold/flush controls out.
interface hazard_ctrl_if import hazard_pkg::*; #(parameter int REG_W = REG_W_DEF);
  logic Mem_RegWr;
  logic Wr_RegWr;
  logic [REG_W-1:0] Mem_Rw;
  logic [REG_W-1:0] Wr_Rw;
  logic [REG_W-1:0] Ex_Rs;
  logic [REG_W-1:0] Ex_Rt;
  logic Ex_MemRead;
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic Br_taken;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic PC_sleep;
  logic IF_ID_sleep;
  logic IF_ID_flush;
  logic ID_Ex_flush;
  modport master (
    output Mem_RegWr, Wr_RegWr, Mem_Rw, Wr_Rw, Ex_Rs, Ex_Rt, Ex_MemRead, ID_Rs, ID_Rt, Br_taken,
    input ALUSrcA, ALUSrcB, PC_sleep, IF_ID_sleep, IF_ID_flush, ID_Ex_flush
  );
  modport slave (
    input Mem_RegWr, Wr_RegWr, Mem_Rw, Wr_Rw, Ex_Rs, Ex_Rt, Ex_MemRead, ID_Rs, ID_Rt, Br_taken,
    output ALUSrcA, ALUSrcB, PC_sleep, IF_ID_sleep, IF_ID_flush, ID_Ex_flush
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: priority forwarding select for one Ex source register; Mem beats Wr, $0 never forwarded.
module fwd_sel import hazard_pkg::*; #(parameter int REG_W = REG_W_DEF) (
  input logic [REG_W-1:0] src_i,
  input logic mem_wr_i,
  input logic [REG_W-1:0] mem_rw_i,
  input logic wr_wr_i,
  input logic [REG_W-1:0] wr_rw_i,
  output logic [1:0] sel_o
);
  logic nz;
  assign nz = |src_i;
  assign sel_o = (nz && mem_wr_i && mem_rw_i == src_i) ? FWD_MEM :
                 (nz && wr_wr_i && wr_rw_i == src_i) ? FWD_WR : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX forwarding selects plus multi-cycle load-use stall FSM with branch-flush priority.
// Define HAZARD_STAT_EN to add saturating stall_cnt/flush_cnt statistics outputs.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int REG_W = REG_W_DEF,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_STAT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] sel_a, sel_b;
  logic lu, stall;
  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src_i(hz.Ex_Rs), .mem_wr_i(hz.Mem_RegWr), .mem_rw_i(hz.Mem_Rw),
    .wr_wr_i(hz.Wr_RegWr), .wr_rw_i(hz.Wr_Rw), .sel_o(sel_a)
  );
  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src_i(hz.Ex_Rt), .mem_wr_i(hz.Mem_RegWr), .mem_rw_i(hz.Mem_Rw),
    .wr_wr_i(hz.Wr_RegWr), .wr_rw_i(hz.Wr_Rw), .sel_o(sel_b)
  );
  assign lu = hz.Ex_MemRead && |hz.Ex_Rt && (hz.Ex_Rt == hz.ID_Rs || hz.Ex_Rt == hz.ID_Rt);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // A taken branch squashes the dependent instruction, so it cancels both a new and an ongoing stall
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stall = !hz.Br_taken && (state_q == HOLD || lu);
    if (hz.Br_taken) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CNT_W'(1) ? IDLE : HOLD;
    end else if (lu && LOAD_LAT > 1) begin
      state_d = HOLD;
      cnt_d = CNT_W'(LOAD_LAT - 1);
    end
  end
  assign hz.ALUSrcA = rst ? FWD_RF : sel_a;
  assign hz.ALUSrcB = rst ? FWD_RF : sel_b;
  assign hz.PC_sleep = !rst && stall;
  assign hz.IF_ID_sleep = !rst && stall;
  assign hz.IF_ID_flush = !rst && hz.Br_taken;
  assign hz.ID_Ex_flush = !rst && (stall || hz.Br_taken);
`ifdef HAZARD_STAT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (hz.Br_taken && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors against LOAD_LAT=1 and LOAD_LAT=3 instances sharing one stimulus.
module tb_hazard_ctrl;
  import hazard_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  localparam logic [3:0] STL = 4'b1101;
  localparam logic [3:0] BRF = 4'b0011;
  hazard_ctrl_if #(.REG_W(5)) h1 ();
  hazard_ctrl_if #(.REG_W(5)) h3 ();
  always #5 clk = ~clk;
  assign h1.Mem_RegWr = h3.Mem_RegWr;
  assign h1.Wr_RegWr = h3.Wr_RegWr;
  assign h1.Mem_Rw = h3.Mem_Rw;
  assign h1.Wr_Rw = h3.Wr_Rw;
  assign h1.Ex_Rs = h3.Ex_Rs;
  assign h1.Ex_Rt = h3.Ex_Rt;
  assign h1.Ex_MemRead = h3.Ex_MemRead;
  assign h1.ID_Rs = h3.ID_Rs;
  assign h1.ID_Rt = h3.ID_Rt;
  assign h1.Br_taken = h3.Br_taken;
`ifdef HAZARD_STAT_EN
  logic [15:0] sc1, fc1, sc3, fc3;
  hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .hz(h1), .stall_cnt(sc1), .flush_cnt(fc1));
  hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (.clk(clk), .rst(rst), .hz(h3), .stall_cnt(sc3), .flush_cnt(fc3));
`else
  hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .hz(h1));
  hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (.clk(clk), .rst(rst), .hz(h3));
`endif
  wire [3:0] c1 = {h1.PC_sleep, h1.IF_ID_sleep, h1.IF_ID_flush, h1.ID_Ex_flush};
  wire [3:0] c3 = {h3.PC_sleep, h3.IF_ID_sleep, h3.IF_ID_flush, h3.ID_Ex_flush};
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    h3.Mem_RegWr = 0; h3.Wr_RegWr = 0; h3.Mem_Rw = 0; h3.Wr_Rw = 0;
    h3.Ex_Rs = 0; h3.Ex_Rt = 0; h3.Ex_MemRead = 0; h3.ID_Rs = 0; h3.ID_Rt = 0; h3.Br_taken = 0;
  endtask
  task automatic haz();
    h3.Ex_MemRead = 1; h3.Ex_Rt = 5; h3.ID_Rt = 5;
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    clr();
    cyc(); rst = 1; h3.Mem_RegWr = 1; h3.Mem_Rw = 8; h3.Ex_Rs = 8; haz(); #1;
    chk("rst_ctl3", c3, 0); chk("rst_ctl1", c1, 0); chk("rst_srca", h3.ALUSrcA, 0);
    cyc(); #1; chk("rst2_ctl3", c3, 0);
    cyc(); rst = 0; clr();
    h3.Mem_RegWr = 1; h3.Mem_Rw = 8; h3.Wr_RegWr = 1; h3.Wr_Rw = 8; h3.Ex_Rs = 8; h3.Ex_Rt = 9; #1;
    chk("fwd_mem_a", h3.ALUSrcA, 1); chk("fwd_rf_b", h3.ALUSrcB, 0);
    h3.Mem_RegWr = 0; #1; chk("fwd_wr_a", h3.ALUSrcA, 2);
    h3.Ex_Rt = 8; h3.Mem_RegWr = 1; h3.Mem_Rw = 3; #1;
    chk("fwd_wr_b", h3.ALUSrcB, 2); chk("fwd_rf_a_nomatch", h3.ALUSrcA, 2);
    cyc(); clr(); h3.Mem_RegWr = 1; h3.Mem_Rw = 0; h3.Wr_RegWr = 1; h3.Wr_Rw = 0;
    h3.Ex_MemRead = 1; #1;
    chk("zero_fwd_a", h3.ALUSrcA, 0); chk("zero_fwd_b", h3.ALUSrcB, 0);
    chk("zero_lu3", c3, 0); chk("zero_lu1", c1, 0);
    cyc(); clr(); haz(); #1; chk("lu_c1_l1", c1, STL); chk("lu_c1_l3", c3, STL);
    cyc(); clr(); #1; chk("lu_c2_l1", c1, 0); chk("lu_c2_l3", c3, STL);
    cyc(); haz(); #1; chk("lu_c3_l1", c1, STL); chk("lu_c3_l3", c3, STL);
    cyc(); clr(); #1; chk("lu_c4_l1", c1, 0); chk("lu_c4_l3", c3, 0);
    cyc(); #1; chk("lu_c5_l3", c3, 0);
    cyc(); haz(); #1; chk("br_c1_l3", c3, STL);
    cyc(); clr(); h3.Br_taken = 1; #1; chk("br_c2_l3", c3, BRF); chk("br_c2_l1", c1, BRF);
    cyc(); clr(); #1; chk("br_c3_l3", c3, 0); chk("br_c3_l1", c1, 0);
    cyc(); haz(); h3.Br_taken = 1; #1; chk("br_lu_l3", c3, BRF); chk("br_lu_l1", c1, BRF);
    cyc(); clr(); #1; chk("br_lu_next_l3", c3, 0); chk("br_lu_next_l1", c1, 0);
    cyc(); haz(); #1; chk("rh_c1_l3", c3, STL);
    cyc(); clr(); rst = 1; h3.Mem_RegWr = 1; h3.Mem_Rw = 4; h3.Ex_Rt = 4; #1;
    chk("rh_rst_l3", c3, 0); chk("rh_rst_srcb", h3.ALUSrcB, 0);
    cyc(); rst = 0; clr(); #1; chk("rh_after_l3", c3, 0);
`ifdef HAZARD_STAT_EN
    chk("stat_clr_s", sc3, 0);
    cyc(); haz(); #1;
    cyc(); clr(); #1;
    cyc(); #1; chk("stat_c3_l3", c3, STL);
    cyc(); h3.Br_taken = 1; #1;
    cyc(); #1;
    cyc(); clr(); #1;
    chk("stat_stall", sc3, 3); chk("stat_flush", fc3, 2);
    chk("stat_stall_l1", sc1, 1); chk("stat_flush_l1", fc1, 2);
    cyc(); rst = 1; #1;
    cyc(); rst = 0; #1;
    chk("stat_rst_s", sc3, 0); chk("stat_rst_f", fc3, 0);
`endif
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Unified hazard unit for the 5-stage MIPS pipeline (IF/ID/Ex/Mem/Wr). It merges the EX-stage operand forwarding selects with load-use stall generation.
- New over the previous combinational units:
  - parametrised register-index width
  - multi-cycle load latency, handled by a stall FSM
  - $0 never forwarded and never treated as a hazard
  - taken-branch flush with priority over stalls
- Sits beside the pipeline registers and drives the PC, IF_ID and ID_Ex hold/flush controls plus both Ex ALU operand muxes.

Parameters:
- REG_W, 5, register index width.
- LOAD_LAT, 1, load-use stall cycles per detected hazard. Range 1..15; 1 gives classic one-bubble behaviour.
- CNT_W, 4, width of the stall down-counter. Must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Mem_RegWr  in  1  Mem-stage instruction writes the register file
- Wr_RegWr  in  1  Wr-stage instruction writes the register file
- Mem_Rw  in  REG_W  Mem-stage destination register
- Wr_Rw  in  REG_W  Wr-stage destination register
- Ex_Rs, Ex_Rt  in  REG_W  Ex-stage source registers
- Ex_MemRead  in  1  Ex-stage instruction is a load
- ID_Rs, ID_Rt  in  REG_W  ID-stage source registers
- Br_taken  in  1  branch/jump resolved taken this cycle
- ALUSrcA, ALUSrcB  out  2  operand select: 00 = register file, 01 = Mem result, 10 = Wr result
- PC_sleep  out  1  hold PC
- IF_ID_sleep  out  1  hold IF_ID register
- IF_ID_flush  out  1  zero IF_ID register
- ID_Ex_flush  out  1  insert bubble into ID_Ex

Behaviour:
- Forwarding (combinational, per operand X in {A,B}, source S in {Ex_Rs, Ex_Rt}):
  - If Mem_RegWr and Mem_Rw==S and S!=0, select 01.
  - Else if Wr_RegWr and Wr_Rw==S and S!=0, select 10.
  - Else select 00.
  - Mem has priority over Wr when both match.
- Hazard detect: lu = Ex_MemRead && Ex_Rt!=0 && (Ex_Rt==ID_Rs || Ex_Rt==ID_Rt).
- Stall FSM states:
  - IDLE:
    - If lu and !Br_taken: assert stall this cycle (combinational).
    - If additionally LOAD_LAT>1: load cnt = LOAD_LAT-1 and go to HOLD.
  - HOLD:
    - Stall is asserted unconditionally.
    - cnt decrements each cycle; at cnt==1 return to IDLE.
    - Stall is therefore asserted for exactly LOAD_LAT consecutive cycles.
    - lu is ignored while in HOLD.
- stall outputs:
  - PC_sleep = IF_ID_sleep = ID_Ex_flush = 1 during stall cycles.
  - ID_Ex_flush stays high for every stall cycle, so each one is a bubble.
- Br_taken (any state), which overrides all stalls:
  - IF_ID_flush=1, ID_Ex_flush=1, PC_sleep=0, IF_ID_sleep=0.
  - FSM forced to IDLE with cnt=0 on the next edge.
  - A lu in the same cycle is discarded, because the dependent instruction is squashed.
- Reset:
  - rst=1 puts the FSM in IDLE with cnt=0.
  - All hold/flush outputs are 0 while rst is high.
  - ALUSrcA/ALUSrcB are 00 while rst is high.
  - Reset during HOLD aborts the stall on that same edge.
- No latches. Every output is fully assigned in every path.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- Defined: adds output stall_cnt[15:0] and output flush_cnt[15:0].
  - stall_cnt increments on each clk where stall is asserted.
  - flush_cnt increments on each clk where Br_taken=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WR=2'b10
  - FSM state typedef {IDLE, HOLD}
  - default REG_W
- One natural sub-module, fwd_sel: one instance per operand (A/B). It implements the priority compare for a single source register.
- The stall FSM stays in the top module.

Test Plan:
1. Mem_RegWr=1, Mem_Rw=8, Wr_RegWr=1, Wr_Rw=8, Ex_Rs=8, Ex_Rt=9 -> ALUSrcA=01, ALUSrcB=00. Then set Mem_RegWr=0 -> ALUSrcA=10.
2. Mem_RegWr=1, Mem_Rw=0, Ex_Rs=0 -> ALUSrcA=00. Also Ex_MemRead=1, Ex_Rt=0, ID_Rs=0 -> no stall.
3. LOAD_LAT=1: Ex_MemRead=1, Ex_Rt=5, ID_Rt=5 for one cycle -> PC_sleep/IF_ID_sleep/ID_Ex_flush high for exactly 1 cycle; FSM stays IDLE.
4. LOAD_LAT=3: the same hazard pulse -> stall high for exactly 3 consecutive cycles, then 0; a second lu during HOLD does not extend it.
5. LOAD_LAT=3: hazard, then Br_taken=1 in the 2nd stall cycle -> that cycle shows IF_ID_flush=1, ID_Ex_flush=1, PC_sleep=0; next cycle FSM is IDLE with all outputs 0.
6. rst=1 asserted mid-HOLD -> all outputs 0 immediately and after the edge. With HAZARD_STAT_EN: after 3 stall cycles and 2 branches, stall_cnt=3, flush_cnt=2; rst clears both.
